prog_loader: RTL and testbench

Upstream neighbour of the pipelined CPU fetch stage. Replaces file-based program preload with a runtime byte-stream loader.
- Receives a framed program over a valid/ready byte interface.
- Packs each 3-byte group into a 19-bit command and writes it into 32-entry program memory.
- Verifies an XOR checksum, then releases the CPU from reset.
- Serves the fetch stage through a combinational read port.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_cmd_packer.sv | 47 ++++
 rtl/prog_loader.sv | 121 ++++++++++++
 tb/tb_prog_loader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared sizes, FSM state encoding and NOP constant for the runtime program loader.
package prog_loader_pkg;

  localparam int CMD_SIZE       = 19;
  localparam int PROG_SIZE      = 32;
  localparam int PROG_ADDR_SIZE = $clog2(PROG_SIZE);
  localparam int BYTE_SIZE      = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [CMD_SIZE-1:0] NOP_CMD = '0;

endpackage

// File: rtl/prog_loader_cmd_packer.sv
// Assembles three stream bytes (MSB first) into one command word.
// Also flags a header byte whose unused upper bits are set.
module cmd_packer
  import prog_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 accept,
  input  logic [BYTE_SIZE-1:0] data,
  output logic                 word_valid,
  output logic [CMD_SIZE-1:0]  word,
  output logic                 hdr_err
);

  logic [1:0]           phase;
  logic [2:0]           hi;
  logic [BYTE_SIZE-1:0] mid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= 2'd0;
      hi    <= '0;
      mid   <= '0;
    end else if (start) begin
      phase <= 2'd0;
    end else if (accept) begin
      case (phase)
        2'd0: begin
          hi    <= data[2:0];
          phase <= 2'd1;
        end
        2'd1: begin
          mid   <= data;
          phase <= 2'd2;
        end
        default: phase <= 2'd0;
      endcase
    end
  end

  // The third byte completes the word in the same cycle it is accepted.
  assign word_valid = accept && (phase == 2'd2);
  assign word       = {hi, mid, data};
  assign hdr_err    = accept && (phase == 2'd0) && (data[7:3] != 5'd0);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: fills program memory, verifies an XOR checksum, releases the CPU.
// Optional inter-byte timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
)
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BYTE_SIZE-1:0]      in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PROG_ADDR_SIZE-1:0] fetch_addr,
  output logic [CMD_SIZE-1:0]       fetch_cmd,
  output logic                      cpu_reset,
  output logic                      load_done,
  output logic                      load_err
);

  logic [2:0]                state;
  logic [2:0]                next_state;
  logic [PROG_ADDR_SIZE:0]   count;
  logic [PROG_ADDR_SIZE:0]   wr_ptr;
  logic [BYTE_SIZE-1:0]      checksum;
  logic [CMD_SIZE-1:0]       mem [PROG_SIZE];
  logic                      accept;
  logic                      load_accept;
  logic                      word_valid;
  logic [CMD_SIZE-1:0]       word;
  logic                      hdr_err;
  logic                      mem_we;
  logic                      timed_out;

  assign in_ready    = (state == S_IDLE) || (state == S_LOAD) || (state == S_CHECK);
  assign accept      = in_valid && in_ready;
  assign load_accept = accept && (state == S_LOAD);
  assign mem_we      = reset && load_accept && word_valid;

  cmd_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .start      (state == S_IDLE),
    .accept     (load_accept),
    .data       (in_data),
    .word_valid (word_valid),
    .word       (word),
    .hdr_err    (hdr_err)
  );

`ifdef PROG_LOADER_TIMEOUT_EN
  logic [31:0] timer;

  // Counts idle cycles while a frame is open; any accept or fresh entry restarts it.
  always_ff @(posedge clk) begin
    if (!reset || accept || !((state == S_LOAD) || (state == S_CHECK))) begin
      timer <= '0;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  assign timed_out = ((state == S_LOAD) || (state == S_CHECK)) && !accept &&
                     (timer + 32'd1 >= 32'(TIMEOUT_CYCLES));
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    next_state = state;
    if (timed_out) begin
      next_state = S_ERROR;
    end else if (accept) begin
      case (state)
        S_IDLE: begin
          if ((in_data == '0) || (in_data > BYTE_SIZE'(PROG_SIZE))) next_state = S_ERROR;
          else next_state = S_LOAD;
        end
        S_LOAD: begin
          if (hdr_err) next_state = S_ERROR;
          else if (word_valid && ((wr_ptr + 1'b1) == count)) next_state = S_CHECK;
        end
        S_CHECK: next_state = (in_data == checksum) ? S_RUN : S_ERROR;
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      count     <= '0;
      wr_ptr    <= '0;
      checksum  <= '0;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= next_state;
      cpu_reset <= (next_state != S_RUN);
      load_done <= (next_state == S_RUN);
      load_err  <= (next_state == S_ERROR);
      if (accept && (state == S_IDLE)) begin
        count    <= in_data[PROG_ADDR_SIZE:0];
        wr_ptr   <= '0;
        checksum <= '0;
      end else if (load_accept) begin
        checksum <= checksum ^ in_data;
        if (word_valid) wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Memory is deliberately left uncleared by reset; stale words are hidden by the count check.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[PROG_ADDR_SIZE-1:0]] <= word;
  end

  assign fetch_cmd = ((state == S_RUN) && ({1'b0, fetch_addr} < count)) ? mem[fetch_addr] : NOP_CMD;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader with hand-computed frames and expected words.
// Timeout cases run only when PROG_LOADER_TIMEOUT_EN is defined.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  fetch_addr;
  logic [18:0] fetch_cmd;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;

  int checkCount = 0;
  int passCount  = 0;

  prog_loader #(.TIMEOUT_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fetch_addr (fetch_addr),
    .fetch_cmd  (fetch_cmd),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // One byte is presented for exactly one rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic checkFetch(input string tag, input logic [4:0] addr, input logic [18:0] expected);
    fetch_addr = addr;
    #1;
    checkOutput(tag, 32'(fetch_cmd), 32'(expected));
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    fetch_addr = 5'd0;

    resetDut();
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("reset_load_done", 32'(load_done), 32'd0);
    checkOutput("reset_load_err",  32'(load_err),  32'd0);
    checkFetch("reset_fetch0", 5'd0, 19'h0);

    // Good frame: N=2, words 0x12345 and 0x00001, checksum 0x66.
    applyStimulus(8'h02);
    applyStimulus(8'h01); applyStimulus(8'h23); applyStimulus(8'h45);
    applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h01);
    checkOutput("pre_chk_cpu_reset", 32'(cpu_reset), 32'd1);
    checkFetch("pre_chk_fetch0", 5'd0, 19'h0);
    applyStimulus(8'h66);
    checkOutput("good_cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("good_load_done", 32'(load_done), 32'd1);
    checkOutput("good_in_ready",  32'(in_ready),  32'd0);
    checkOutput("good_load_err",  32'(load_err),  32'd0);
    checkFetch("good_fetch0", 5'd0, 19'h12345);
    checkFetch("good_fetch1", 5'd1, 19'h00001);
    checkFetch("good_fetch5", 5'd5, 19'h0);
    applyStimulus(8'h55);
    checkOutput("run_ignore_done", 32'(load_done), 32'd1);
    checkFetch("run_ignore_fetch0", 5'd0, 19'h12345);

    // Reset in RUN re-asserts cpu_reset on that edge.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("run_reset_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("run_reset_load_done", 32'(load_done), 32'd0);
    reset = 1'b1;

    // Bad checksum.
    applyStimulus(8'h02);
    applyStimulus(8'h01); applyStimulus(8'h23); applyStimulus(8'h45);
    applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h01);
    applyStimulus(8'h67);
    checkOutput("badchk_load_err",  32'(load_err),  32'd1);
    checkOutput("badchk_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("badchk_in_ready",  32'(in_ready),  32'd0);
    checkOutput("badchk_load_done", 32'(load_done), 32'd0);
    checkFetch("badchk_fetch0", 5'd0, 19'h0);
    checkFetch("badchk_fetch1", 5'd1, 19'h0);

    // COUNT boundaries: 0 and 33 fail, 32 is accepted.
    resetDut();
    applyStimulus(8'h00);
    checkOutput("count0_err", 32'(load_err), 32'd1);
    resetDut();
    applyStimulus(8'h21);
    checkOutput("count33_err", 32'(load_err), 32'd1);
    resetDut();
    applyStimulus(8'h20);
    checkOutput("count32_err",   32'(load_err), 32'd0);
    checkOutput("count32_ready", 32'(in_ready), 32'd1);

    // Header byte with bit 3 set.
    resetDut();
    applyStimulus(8'h01);
    applyStimulus(8'h08);
    checkOutput("hdr_err",       32'(load_err), 32'd1);
    checkOutput("hdr_in_ready",  32'(in_ready), 32'd0);

    // Partial 32-word frame with random gaps, then reset and an N=1 frame.
    resetDut();
    applyStimulus(8'h20);
    for (int i = 0; i < 10; i++) begin
      idleCycles($urandom_range(0, 3));
      applyStimulus(8'h07);
      idleCycles($urandom_range(0, 3));
      applyStimulus(8'hAA);
      idleCycles($urandom_range(0, 3));
      applyStimulus(8'(i));
    end
    checkOutput("midframe_err",   32'(load_err), 32'd0);
    checkOutput("midframe_ready", 32'(in_ready), 32'd1);
    resetDut();
    checkOutput("midreset_done", 32'(load_done), 32'd0);
    applyStimulus(8'h01);
    applyStimulus(8'h05); applyStimulus(8'h5A); applyStimulus(8'hC3);
    applyStimulus(8'h9C);
    checkOutput("n1_load_done", 32'(load_done), 32'd1);
    checkOutput("n1_cpu_reset", 32'(cpu_reset), 32'd0);
    checkFetch("n1_fetch0",  5'd0,  19'h55AC3);
    checkFetch("n1_fetch1",  5'd1,  19'h0);
    checkFetch("n1_fetch9",  5'd9,  19'h0);
    checkFetch("n1_fetch31", 5'd31, 19'h0);

`ifdef PROG_LOADER_TIMEOUT_EN
    // Stall of 10 idle cycles after the 4th byte must time out.
    resetDut();
    applyStimulus(8'h02);
    applyStimulus(8'h01); applyStimulus(8'h23); applyStimulus(8'h45);
    idleCycles(9);
    checkOutput("stall9_no_err", 32'(load_err), 32'd0);
    idleCycles(1);
    checkOutput("stall10_err", 32'(load_err), 32'd1);

    // Stall of 9 idle cycles then a byte is tolerated.
    resetDut();
    applyStimulus(8'h02);
    applyStimulus(8'h01); applyStimulus(8'h23); applyStimulus(8'h45);
    idleCycles(8);
    applyStimulus(8'h00);
    checkOutput("stall9_byte_err", 32'(load_err), 32'd0);
    applyStimulus(8'h00); applyStimulus(8'h01);
    applyStimulus(8'h66);
    checkOutput("stall9_done", 32'(load_done), 32'd1);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
